// File: rtl/apb_seq_pkg.sv
// Shared types for the APB command sequencer: FSM states, queued command
// layout and the data value returned on a timed-out read.
package apb_seq_pkg;

  localparam int CMD_ADDR_W = 32;
  localparam int CMD_DATA_W = 32;

  localparam logic [CMD_DATA_W-1:0] TIMEOUT_DATA = '0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic                  write;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Generic synchronous FIFO with push/pop, full/empty and occupancy count.
// A push while full is dropped; a pop while empty is ignored.
module apb_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: nothing is read until count says it is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/apb_cmd_sequencer.sv
// Buffers host commands and issues them one at a time to the APB master
// request interface, returning read data (or a timeout error) to the host.
//
// state    | meaning
// IDLE     | TRANSFER low; waiting for a queued command that may issue
// ISSUE    | TRANSFER high with head command; waiting for xfer_done or timeout
// WAIT_RSP | read response held on rsp_* until the host accepts it
module apb_cmd_sequencer
  import apb_seq_pkg::*;
#(
  parameter int ADDR_W  = CMD_ADDR_W,
  parameter int DATA_W  = CMD_DATA_W,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              TRANSFER,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  output logic              write_en,
  input  logic [DATA_W-1:0] read_data,
  input  logic              xfer_done,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              timeout_sticky
);

  localparam int                CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT - 1);

  seq_state_t              state_q;
  seq_state_t              state_d;
  cmd_t                    push_cmd;
  cmd_t                    head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic [CNT_W-1:0]        tmo_cnt;
  logic                    load;
  logic                    pop;
  logic                    done_ok;
  logic                    expire;
  logic                    rsp_take;

  assign cmd_ready = ~fifo_full;

  always_comb begin
    push_cmd       = '0;
    push_cmd.write = cmd_write;
    push_cmd.addr  = CMD_ADDR_W'(cmd_addr);
    push_cmd.wdata = CMD_DATA_W'(cmd_wdata);
  end

  apb_cmd_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (PCLK),
    .rst_n     (PRESETn),
    .push      (cmd_valid),
    .push_data (push_cmd),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // xfer_done wins over a timeout expiring in the same cycle.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    pop      = 1'b0;
    done_ok  = 1'b0;
    expire   = 1'b0;
    rsp_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && (head.write || !rsp_valid)) begin
          state_d = ISSUE;
          load    = 1'b1;
        end
      end
      ISSUE: begin
        if (xfer_done) begin
          pop     = 1'b1;
          done_ok = 1'b1;
          state_d = write_en ? IDLE : WAIT_RSP;
        end else if (tmo_cnt == TMO_LAST) begin
          pop     = 1'b1;
          expire  = 1'b1;
          state_d = write_en ? IDLE : WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (rsp_valid && rsp_ready) begin
          rsp_take = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      TRANSFER       <= 1'b0;
      address        <= '0;
      write_data     <= '0;
      write_en       <= 1'b0;
      tmo_cnt        <= '0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_err        <= 1'b0;
      timeout_sticky <= 1'b0;
      busy           <= 1'b0;
    end else begin
      busy <= ~fifo_empty | (state_q != IDLE);

      if (load) begin
        TRANSFER   <= 1'b1;
        address    <= ADDR_W'(head.addr);
        write_data <= DATA_W'(head.wdata);
        write_en   <= head.write;
        tmo_cnt    <= '0;
      end else if (state_q == ISSUE && tmo_cnt != TMO_LAST) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      if (pop) TRANSFER <= 1'b0;

      if (done_ok && !write_en) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= read_data;
        rsp_err   <= 1'b0;
      end

      if (expire) begin
        timeout_sticky <= 1'b1;
        if (!write_en) begin
          rsp_valid <= 1'b1;
          rsp_rdata <= DATA_W'(TIMEOUT_DATA);
          rsp_err   <= 1'b1;
        end
      end

      if (rsp_take) rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// Directed bench for apb_cmd_sequencer with a behavioural APB master model
// that completes each TRANSFER after a programmable number of cycles.
module tb_apb_cmd_sequencer;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        TRANSFER;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        write_en;
  logic [31:0] read_data;
  logic        xfer_done;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        timeout_sticky;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_lat = 3;
  logic [31:0] mem_model [logic [31:0]];

  int hi_len = 0, last_len = 0, low_len = 0, last_gap = 0;
  int n_pulses = 0, n_rises = 0, stab_err = 0, rsp_seen = 0;
  int t_fall = 0, b_fall = 0;
  logic [31:0] cap_addr = '0, cap_wdata = '0;
  logic cap_we = 1'b0, prev_tr = 1'b0, prev_busy = 1'b0;
  int base;

  apb_cmd_sequencer dut (
    .PCLK           (PCLK),
    .PRESETn        (PRESETn),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_addr       (cmd_addr),
    .cmd_wdata      (cmd_wdata),
    .TRANSFER       (TRANSFER),
    .address        (address),
    .write_data     (write_data),
    .write_en       (write_en),
    .read_data      (read_data),
    .xfer_done      (xfer_done),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .busy           (busy),
    .timeout_sticky (timeout_sticky)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc++;

  // Master model: xfer_done in the done_lat-th cycle of TRANSFER (0 = never).
  initial begin
    int hi_cnt;
    hi_cnt = 0;
    xfer_done = 1'b0;
    read_data = '0;
    forever begin
      @(posedge PCLK);
      #1;
      xfer_done = 1'b0;
      read_data = '0;
      if (TRANSFER) begin
        hi_cnt++;
        if (done_lat != 0 && hi_cnt == done_lat) begin
          xfer_done = 1'b1;
          if (write_en) mem_model[address] = write_data;
          else read_data = mem_model.exists(address) ? mem_model[address] : 32'h0;
        end
      end else begin
        hi_cnt = 0;
      end
    end
  end

  // Bus monitor: pulse lengths, gaps, request stability, busy timing.
  initial begin
    forever begin
      @(negedge PCLK);
      if (TRANSFER) begin
        if (!prev_tr) begin
          last_gap  = low_len;
          hi_len    = 1;
          n_rises++;
          cap_addr  = address;
          cap_wdata = write_data;
          cap_we    = write_en;
        end else begin
          hi_len++;
          if (address !== cap_addr || write_data !== cap_wdata || write_en !== cap_we)
            stab_err++;
        end
        low_len = 0;
      end else begin
        if (prev_tr) begin
          last_len = hi_len;
          n_pulses++;
          t_fall = cyc;
        end
        low_len++;
      end
      if (prev_busy && !busy) b_fall = cyc;
      if (rsp_valid) rsp_seen++;
      prev_tr   = TRANSFER;
      prev_busy = busy;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
    int t;
    t = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready && t < 200) begin
      tick(1);
      t++;
    end
    check("push_ready", cmd_ready, 1);
    tick(1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int budget);
    int t;
    t = 0;
    while (!rsp_valid && t < budget) begin
      tick(1);
      t++;
    end
    check(tag, rsp_valid, 1);
    @(negedge PCLK);
    #1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int t;
    t = 0;
    tick(1);
    while (busy && t < budget) begin
      tick(1);
      t++;
    end
    check(tag, busy, 0);
    @(negedge PCLK);
    #1;
  endtask

  initial begin
    tick(3);
    check("rst_transfer", TRANSFER, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_sticky", timeout_sticky, 0);
    PRESETn = 1'b1;
    tick(2);
    check("rst_addr", address, 0);
    check("rst_rsp_err", rsp_err, 0);

    // Single write, master completes after 3 cycles
    done_lat = 3;
    push_cmd(1'b1, 32'h10, 32'hA5A5_0001);
    wait_idle("t1_idle", 50);
    check("t1_pulses", n_pulses, 1);
    check("t1_len", last_len, 3);
    check("t1_stable", stab_err, 0);
    check("t1_addr", cap_addr, 32'h10);
    check("t1_wdata", cap_wdata, 32'hA5A5_0001);
    check("t1_we", cap_we, 1);
    check("t1_no_rsp", rsp_seen, 0);
    check("t1_busy_lag", b_fall - t_fall, 1);

    // Write then read back through the echo slave
    push_cmd(1'b1, 32'h20, 32'h1234_5678);
    push_cmd(1'b0, 32'h20, 32'h0);
    wait_rsp("t2_rsp", 100);
    check("t2_rdata", rsp_rdata, 32'h1234_5678);
    check("t2_err", rsp_err, 0);
    check("t2_pulses", n_pulses, 3);
    check("t2_gap", 32'(last_gap >= 1), 1);
    check("t2_read_addr", cap_addr, 32'h20);
    check("t2_read_we", cap_we, 0);
    tick(5);
    check("t2_hold_valid", rsp_valid, 1);
    check("t2_hold_rdata", rsp_rdata, 32'h1234_5678);
    rsp_ready = 1'b1;
    tick(1);
    rsp_ready = 1'b0;
    check("t2_accepted", rsp_valid, 0);
    check("t2_stable", stab_err, 0);

    // Five reads with the host stalled: FIFO fills, responses drain in order
    for (int i = 0; i < 5; i++) mem_model[32'h100 + 32'(i * 4)] = 32'hC0DE_0000 + 32'(i);
    base = n_pulses;
    for (int i = 0; i < 4; i++) push_cmd(1'b0, 32'h100 + 32'(i * 4), 32'h0);
    check("t3_full_ready", cmd_ready, 0);
    push_cmd(1'b0, 32'h110, 32'h0);
    tick(10);
    check("t3_full_again", cmd_ready, 0);
    check("t3_rsp_held", rsp_valid, 1);
    check("t3_rsp0", rsp_rdata, 32'hC0DE_0000);
    check("t3_no_issue", TRANSFER, 0);
    check("t3_one_pulse", n_pulses - base, 1);
    rsp_ready = 1'b1;
    tick(1);
    for (int i = 1; i < 5; i++) begin
      wait_rsp("t3_rsp_wait", 100);
      check("t3_rsp_data", rsp_rdata, 32'hC0DE_0000 + 32'(i));
      check("t3_rsp_err", rsp_err, 0);
      tick(1);
    end
    rsp_ready = 1'b0;
    wait_idle("t3_idle", 50);
    check("t3_pulses", n_pulses - base, 5);
    check("t3_ready", cmd_ready, 1);

    // xfer_done in the last cycle before timeout counts as success
    done_lat = 64;
    push_cmd(1'b0, 32'h20, 32'h0);
    wait_rsp("t5_rsp", 200);
    check("t5_len", last_len, 64);
    check("t5_rdata", rsp_rdata, 32'h1234_5678);
    check("t5_err", rsp_err, 0);
    check("t5_sticky", timeout_sticky, 0);
    rsp_ready = 1'b1;
    tick(1);
    rsp_ready = 1'b0;

    // Hung slave: read times out, queued write still goes out
    done_lat = 0;
    push_cmd(1'b0, 32'h40, 32'h0);
    push_cmd(1'b1, 32'h44, 32'h0000_BEEF);
    wait_rsp("t4_rsp", 200);
    check("t4_len", last_len, 64);
    check("t4_rdata", rsp_rdata, 32'h0);
    check("t4_err", rsp_err, 1);
    check("t4_sticky", timeout_sticky, 1);
    check("t4_transfer_low", TRANSFER, 0);
    done_lat = 3;
    base = n_pulses;
    tick(3);
    check("t4_hold_err", rsp_err, 1);
    rsp_ready = 1'b1;
    tick(1);
    rsp_ready = 1'b0;
    wait_idle("t4_idle", 50);
    check("t4_write_issued", n_pulses - base, 1);
    check("t4_write_addr", cap_addr, 32'h44);
    check("t4_write_we", cap_we, 1);
    check("t4_write_len", last_len, 3);
    check("t4_mem", mem_model.exists(32'h44) ? mem_model[32'h44] : 32'h0, 32'h0000_BEEF);
    check("t4_sticky_kept", timeout_sticky, 1);

    // Reset while a write is stuck in ISSUE with three more queued
    done_lat = 0;
    for (int i = 0; i < 4; i++) push_cmd(1'b1, 32'h80 + 32'(i * 4), 32'h5A00_0000 + 32'(i));
    tick(3);
    check("t6_in_issue", TRANSFER, 1);
    #2;
    PRESETn = 1'b0;
    #1;
    check("t6_async_transfer", TRANSFER, 0);
    check("t6_async_busy", busy, 0);
    check("t6_async_ready", cmd_ready, 1);
    check("t6_async_sticky", timeout_sticky, 0);
    check("t6_async_rsp", rsp_valid, 0);
    tick(2);
    PRESETn = 1'b1;
    @(negedge PCLK);
    #1;
    base = n_rises;
    done_lat = 3;
    tick(20);
    check("t6_no_stale", n_rises - base, 0);
    check("t6_transfer", TRANSFER, 0);
    check("t6_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
